// File: rtl/uart_tx.sv
// uart_tx: configurable UART transmitter.
// One frame per rising edge of send: start bit, 7 or 8 data bits LSB first,
// optional parity bit, then one or two stop bits. Baud rate, parity,
// character length and stop-bit count are captured when a frame is accepted.
// Optional feature macro: UART_TX_PARITY_EN builds the parity logic; without it
// parity_type is ignored, no parity bit is ever sent and p_parity_out stays 0.
// Outputs are registered, so the line changes one clock after the FSM state.

module uart_tx #(
   parameter int CLK_FREQ = 50_000_000
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       send,
   input  logic [1:0] buad_rate,
   input  logic [7:0] data_in,
   input  logic [1:0] parity_type,
   input  logic       stop_bits,
   input  logic       data_length,
   output logic       data_out,
   output logic       p_parity_out,
   output logic       tx_active,
   output logic       tx_done
);

   // Bit periods rounded to the nearest whole clock count
   localparam int DIV_2400  = (CLK_FREQ + 1200) / 2400;
   localparam int DIV_4800  = (CLK_FREQ + 2400) / 4800;
   localparam int DIV_9600  = (CLK_FREQ + 4800) / 9600;
   localparam int DIV_19200 = (CLK_FREQ + 9600) / 19200;

   // The slowest rate needs the widest counter; never narrower than 15 bits
   localparam int CNT_W = ($clog2(DIV_2400) > 15) ? $clog2(DIV_2400) : 15;

   localparam logic [CNT_W-1:0] LAST_2400  = CNT_W'(DIV_2400 - 1);
   localparam logic [CNT_W-1:0] LAST_4800  = CNT_W'(DIV_4800 - 1);
   localparam logic [CNT_W-1:0] LAST_9600  = CNT_W'(DIV_9600 - 1);
   localparam logic [CNT_W-1:0] LAST_19200 = CNT_W'(DIV_19200 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_DONE
   } state_t;

   state_t           state;
   state_t           next_state;

   logic             send_q;
   logic             armed;
   logic [7:0]       data_q;
   logic [1:0]       baud_q;
   logic             par_en_q;
   logic             stop_q;
   logic             len_q;
   logic             parity_q;

   logic [CNT_W-1:0] baud_cnt;
   logic [CNT_W-1:0] bit_last;
   logic [2:0]       bit_idx;
   logic             stop_idx;

   logic             send_edge;
   logic             bit_end;
   logic             last_data;
   logic             par_en_in;
   logic             par_bit_in;

   logic             data_out_d;
   logic             tx_active_d;
   logic             tx_done_d;

   // armed stays low after reset until send has been seen low, so a send
   // already high at reset release cannot masquerade as a fresh edge
   assign send_edge = send & ~send_q & armed;
   assign bit_end   = (baud_cnt == bit_last);
   assign last_data = (bit_idx == (len_q ? 3'd7 : 3'd6));

`ifdef UART_TX_PARITY_EN
   // Parity enable and bit computed from the live inputs, captured on accept
   always_comb begin
      par_en_in  = (parity_type == 2'b01) || (parity_type == 2'b10);
      par_bit_in = (^(data_in & (data_length ? 8'hFF : 8'h7F))) ^ (parity_type == 2'b01);
   end
`else
   logic unused_parity_type;
   assign unused_parity_type = ^parity_type;
   assign par_en_in          = 1'b0;
   assign par_bit_in         = 1'b0;
`endif

   // Terminal count of the baud counter for the latched rate
   always_comb begin
      bit_last = LAST_2400;
      case (baud_q)
         2'b00:   bit_last = LAST_2400;
         2'b01:   bit_last = LAST_4800;
         2'b10:   bit_last = LAST_9600;
         default: bit_last = LAST_19200;
      endcase
   end

   // State register plus the frame settings captured when a frame is accepted
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         send_q   <= 1'b0;
         armed    <= 1'b0;
         data_q   <= 8'h00;
         baud_q   <= 2'b00;
         par_en_q <= 1'b0;
         stop_q   <= 1'b0;
         len_q    <= 1'b0;
         parity_q <= 1'b0;
      end else begin
         state  <= next_state;
         send_q <= send;
         armed  <= armed | ~send;
         if (state == S_IDLE && send_edge) begin
            data_q   <= data_in;
            baud_q   <= buad_rate;
            par_en_q <= par_en_in;
            stop_q   <= stop_bits;
            len_q    <= data_length;
            parity_q <= par_en_in & par_bit_in;
         end
      end
   end

   // Baud counter reloads at every bit boundary; bit and stop indices advance on it
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         stop_idx <= 1'b0;
      end else begin
         if (state == S_IDLE || state == S_DONE || bit_end) begin
            baud_cnt <= '0;
         end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
         end

         if (state == S_DATA) begin
            if (bit_end) begin
               bit_idx <= bit_idx + 3'd1;
            end
         end else begin
            bit_idx <= 3'd0;
         end

         if (state == S_STOP) begin
            if (bit_end) begin
               stop_idx <= 1'b1;
            end
         end else begin
            stop_idx <= 1'b0;
         end
      end
   end

   // Frame sequencing: each line-driving state lasts one or more whole bit periods
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (send_edge) begin
               next_state = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               next_state = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end && last_data) begin
               next_state = par_en_q ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               next_state = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end && (stop_idx == stop_q)) begin
               next_state = S_DONE;
            end
         end
         S_DONE: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Line level and status flags decoded from the current state
   always_comb begin
      data_out_d  = 1'b1;
      tx_active_d = 1'b0;
      tx_done_d   = 1'b0;
      case (state)
         S_START: begin
            data_out_d  = 1'b0;
            tx_active_d = 1'b1;
         end
         S_DATA: begin
            data_out_d  = data_q[bit_idx];
            tx_active_d = 1'b1;
         end
         S_PARITY: begin
            data_out_d  = parity_q;
            tx_active_d = 1'b1;
         end
         S_STOP: begin
            tx_active_d = 1'b1;
         end
         S_DONE: begin
            tx_done_d = 1'b1;
         end
         default: begin
            data_out_d = 1'b1;
         end
      endcase
   end

   // Registered outputs keep the pin glitch-free; reset forces the line high
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         data_out  <= 1'b1;
         tx_active <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         data_out  <= data_out_d;
         tx_active <= tx_active_d;
         tx_done   <= tx_done_d;
      end
   end

   assign p_parity_out = parity_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx.
// Stimulus pushes each hand-computed frame into a queue; a monitor pops it when
// the line drops and checks every bit, the start latency, tx_done/tx_active
// timing and p_parity_out. A small CLK_FREQ keeps bit periods short:
// 2400->42, 4800->21, 9600->10, 19200->5 clocks.

module tb_uart_tx;

   localparam int CLK_FREQ = 100_000;

`ifdef UART_TX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clock;
   logic       rst;
   logic       send;
   logic [1:0] buad_rate;
   logic [7:0] data_in;
   logic [1:0] parity_type;
   logic       stop_bits;
   logic       data_length;
   logic       data_out;
   logic       p_parity_out;
   logic       tx_active;
   logic       tx_done;

   int cyc = 0;
   int vec_cnt = 0;
   int err_cnt = 0;
   int frame_id = 0;

   typedef struct {
      logic [11:0] bits;
      int          nbits;
      int          bdiv;
      logic        par;
      int          start_cyc;
      int          id;
   } exp_t;

   exp_t sb[$];
   logic mon_busy = 1'b0;

   uart_tx #(.CLK_FREQ(CLK_FREQ)) dut (
      .clock        (clock),
      .rst          (rst),
      .send         (send),
      .buad_rate    (buad_rate),
      .data_in      (data_in),
      .parity_type  (parity_type),
      .stop_bits    (stop_bits),
      .data_length  (data_length),
      .data_out     (data_out),
      .p_parity_out (p_parity_out),
      .tx_active    (tx_active),
      .tx_done      (tx_done)
   );

   // Free-running clock and cycle counter
   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vec_cnt++;
      if (actual !== expected) begin
         err_cnt++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Drive one frame request and push its expected frame; send released unless hold
   task automatic applyStimulus(input logic [1:0] baud, input logic [7:0] data, input logic [1:0] ptype,
                                input logic stop, input logic len, input logic [11:0] bits,
                                input int nbits, input int bdiv, input logic par, input logic hold);
      exp_t e;
      @(negedge clock);
      buad_rate   = baud;
      data_in     = data;
      parity_type = ptype;
      stop_bits   = stop;
      data_length = len;
      send        = 1'b1;
      e.bits      = bits;
      e.nbits     = nbits;
      e.bdiv      = bdiv;
      e.par       = par;
      e.start_cyc = cyc + 2;
      e.id        = frame_id;
      frame_id++;
      sb.push_back(e);
      if (!hold) begin
         repeat (3) @(negedge clock);
         send = 1'b0;
      end
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      while ((sb.size() != 0 || mon_busy) && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (n >= budget) checkOutput("idle_timeout", 32'd1, 32'd0);
   endtask

   // Monitor: pops the expected frame on the start bit and checks it to tx_done
   initial begin : monitor
      exp_t        cur;
      int          t0;
      int          off;
      int          idx;
      logic [11:0] got;
      logic        act_ok;
      logic        done_early;
      logic        spur;
      t0 = 0; idx = 0; got = '0; act_ok = 1'b0; done_early = 1'b0; spur = 1'b0;
      forever begin
         @(negedge clock);
         if (rst) begin
            mon_busy = 1'b0;
         end else if (!mon_busy) begin
            if (tx_done) checkOutput("spurious_tx_done", {31'd0, tx_done}, 32'd0);
            if (data_out) begin
               spur = 1'b0;
            end else if (sb.size() != 0) begin
               cur        = sb.pop_front();
               mon_busy   = 1'b1;
               t0         = cyc;
               idx        = 0;
               got        = '0;
               act_ok     = tx_active;
               done_early = 1'b0;
               checkOutput($sformatf("f%0d_start_cycle", cur.id), t0, cur.start_cyc);
            end else if (!spur) begin
               checkOutput("spurious_frame", {31'd0, data_out}, 32'd1);
               spur = 1'b1;
            end
         end else begin
            off = cyc - t0;
            if (off < cur.nbits * cur.bdiv) begin
               if ((off % cur.bdiv) == (cur.bdiv / 2) && idx < 12) begin
                  got[idx] = data_out;
                  idx++;
               end
               if (!tx_active) act_ok = 1'b0;
               if (tx_done) done_early = 1'b1;
            end else begin
               checkOutput($sformatf("f%0d_bits", cur.id), {20'd0, got}, {20'd0, cur.bits});
               checkOutput($sformatf("f%0d_active_span", cur.id), {31'd0, act_ok}, 32'd1);
               checkOutput($sformatf("f%0d_no_early_done", cur.id), {31'd0, done_early}, 32'd0);
               checkOutput($sformatf("f%0d_tx_done", cur.id), {31'd0, tx_done}, 32'd1);
               checkOutput($sformatf("f%0d_active_fall", cur.id), {31'd0, tx_active}, 32'd0);
               checkOutput($sformatf("f%0d_parity_out", cur.id), {31'd0, p_parity_out}, {31'd0, cur.par});
               checkOutput($sformatf("f%0d_line_at_done", cur.id), {31'd0, data_out}, 32'd1);
               mon_busy = 1'b0;
            end
         end
      end
   end

   // Directed sequence
   initial begin : stimulus
      rst         = 1'b1;
      send        = 1'b0;
      buad_rate   = 2'b00;
      data_in     = 8'h00;
      parity_type = 2'b00;
      stop_bits   = 1'b0;
      data_length = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("reset_data_out", {31'd0, data_out}, 32'd1);
      checkOutput("reset_parity_out", {31'd0, p_parity_out}, 32'd0);
      checkOutput("reset_tx_active", {31'd0, tx_active}, 32'd0);
      checkOutput("reset_tx_done", {31'd0, tx_done}, 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clock);

      // 9600, no parity, 7-bit, 1 stop, 0x5D; send held high afterwards
      applyStimulus(2'b10, 8'h5D, 2'b00, 1'b0, 1'b0, 12'h1BA, 9, 10, 1'b0, 1'b1);
      waitIdle(2000);
      repeat (100) @(negedge clock);
      checkOutput("hold_send_line", {31'd0, data_out}, 32'd1);
      checkOutput("hold_send_active", {31'd0, tx_active}, 32'd0);
      send = 1'b0;
      repeat (3) @(negedge clock);

      // 2400, odd parity, 7-bit, 0x53: parity bit 1
      applyStimulus(2'b00, 8'h53, 2'b01, 1'b0, 1'b0, PAR_EN ? 12'h3A6 : 12'h1A6,
                    PAR_EN ? 10 : 9, 42, PAR_EN, 1'b0);
      waitIdle(2000);

      // 19200, even parity, 8-bit, 0x95: parity bit 0
      applyStimulus(2'b11, 8'h95, 2'b10, 1'b0, 1'b1, PAR_EN ? 12'h52A : 12'h32A,
                    PAR_EN ? 11 : 10, 5, 1'b0, 1'b0);
      waitIdle(2000);

      // 19200, odd parity, 8-bit, 0xE9: parity bit 0
      applyStimulus(2'b11, 8'hE9, 2'b01, 1'b0, 1'b1, PAR_EN ? 12'h5D2 : 12'h3D2,
                    PAR_EN ? 11 : 10, 5, 1'b0, 1'b0);
      waitIdle(2000);

      // 4800, no parity, 7-bit, 2 stop, 0x15
      applyStimulus(2'b01, 8'h15, 2'b00, 1'b1, 1'b0, 12'h32A, 10, 21, 1'b0, 1'b0);
      waitIdle(2000);

      // 9600, parity code 11 (none), 8-bit, 0xA5; retrigger and input changes mid-frame
      applyStimulus(2'b10, 8'hA5, 2'b11, 1'b0, 1'b1, 12'h34A, 10, 10, 1'b0, 1'b0);
      repeat (25) @(negedge clock);
      data_in     = 8'hFF;
      buad_rate   = 2'b00;
      parity_type = 2'b01;
      stop_bits   = 1'b1;
      data_length = 1'b0;
      send        = 1'b1;
      repeat (3) @(negedge clock);
      send = 1'b0;
      waitIdle(2000);
      repeat (200) @(negedge clock);
      checkOutput("no_retrigger_line", {31'd0, data_out}, 32'd1);

      // Reset in the middle of data bit 1 (a 0 bit) of a 0x5D frame
      applyStimulus(2'b10, 8'h5D, 2'b00, 1'b0, 1'b0, 12'h1BA, 9, 10, 1'b0, 1'b1);
      repeat (27) @(negedge clock);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort_data_out", {31'd0, data_out}, 32'd1);
      checkOutput("abort_tx_active", {31'd0, tx_active}, 32'd0);
      checkOutput("abort_tx_done", {31'd0, tx_done}, 32'd0);
      repeat (4) @(negedge clock);
      #2 rst = 1'b0;
      repeat (150) @(negedge clock);
      checkOutput("send_high_at_release_line", {31'd0, data_out}, 32'd1);
      checkOutput("send_high_at_release_active", {31'd0, tx_active}, 32'd0);
      send = 1'b0;
      repeat (3) @(negedge clock);

      // Fresh frame after reset: 9600, even parity, 7-bit, 2 stop, 0x07: parity bit 1
      applyStimulus(2'b10, 8'h07, 2'b10, 1'b1, 1'b0, PAR_EN ? 12'h70E : 12'h30E,
                    PAR_EN ? 11 : 10, 10, PAR_EN, 1'b0);
      waitIdle(2000);
      repeat (20) @(negedge clock);

      checkOutput("scoreboard_empty", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
